// File: rtl/bs_gnrtr_n_rbtr.sv
// Shared-bus generator and round-robin arbiter.
// For each of `bits` independent buses, pops one packet at a time from the
// pending FIFO heads of `drvrs` devices and routes it by its 8-bit
// destination field. The packet goes to one device, or to every device except
// the source when the destination is `broadcast`. Any other destination drops
// the packet.
//
// Ports:
//   clk     - rising-edge clock
//   reset   - asynchronous, active-high reset
//   pndng   - [bits][drvrs] device has a packet at its FIFO head
//   D_pop   - [bits][drvrs][pckg_sz] FIFO head packet per device
//   pop     - [bits][drvrs] one-cycle strobe consuming a device's FIFO head
//   push    - [bits][drvrs] one-cycle strobe delivering a packet to a device
//   D_push  - [bits][drvrs][pckg_sz] delivered packet; holds between transfers
module bs_gnrtr_n_rbtr #(
  parameter int unsigned bits      = 1,
  parameter int unsigned drvrs     = 4,
  parameter int unsigned pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [bits-1:0][drvrs-1:0]                 pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]    D_pop,
  output logic [bits-1:0][drvrs-1:0]                 pop,
  output logic [bits-1:0][drvrs-1:0]                 push,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]    D_push
);

  localparam int unsigned PtrW = (drvrs > 1) ? $clog2(drvrs) : 1;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StRoute = 1'b1;

  for (genvar b = 0; b < bits; b++) begin : g_bus
    logic [0:0]                        state_q;
    logic [PtrW-1:0]                   ptr_q;
    logic [PtrW-1:0]                   src_q;
    logic [pckg_sz-1:0]                pkt_q;
    logic [drvrs-1:0]                  pop_q;
    logic [drvrs-1:0]                  push_q;
    logic [drvrs-1:0]                  push_d;
    logic [drvrs-1:0][pckg_sz-1:0]     dpush_q;
    logic [PtrW-1:0]                   grant_idx;
    logic                              grant_found;
    logic [7:0]                        dest;

    // Round-robin search starting at the pointer. Walking the offsets from
    // the far end down lets the nearest pending device overwrite the others.
    always_comb begin
      logic [PtrW-1:0] idx;
      grant_found = 1'b0;
      grant_idx   = '0;
      idx         = '0;
      for (int k = drvrs - 1; k >= 0; k--) begin
        idx = PtrW'((int'(ptr_q) + k) % int'(drvrs));
        if (pndng[b][idx]) begin
          grant_found = 1'b1;
          grant_idx   = idx;
        end
      end
    end

    // Destination decode of the captured packet.
    always_comb begin
      push_d = '0;
      dest   = pkt_q[pckg_sz-1 -: 8];
      if (int'(dest) < int'(drvrs)) begin
        push_d[PtrW'(dest)] = 1'b1;
      end else if (dest == broadcast) begin
        push_d        = '1;
        push_d[src_q] = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= StIdle;
        ptr_q   <= '0;
        src_q   <= '0;
        pkt_q   <= '0;
        pop_q   <= '0;
        push_q  <= '0;
        dpush_q <= '0;
      end else begin
        pop_q  <= '0;
        push_q <= '0;
        case (state_q)
          StIdle: begin
            if (grant_found) begin
              pop_q[grant_idx] <= 1'b1;
              pkt_q            <= D_pop[b][grant_idx];
              src_q            <= grant_idx;
              state_q          <= StRoute;
            end
          end
          StRoute: begin
            push_q <= push_d;
            for (int j = 0; j < drvrs; j++) begin
              dpush_q[j] <= pkt_q;
            end
            ptr_q   <= (src_q == PtrW'(drvrs - 1)) ? '0 : src_q + 1'b1;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end

    assign pop[b]    = pop_q;
    assign push[b]   = push_q;
    assign D_push[b] = dpush_q;
  end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Self-checking bench for bs_gnrtr_n_rbtr (1 bus, 8 devices, 30-bit packets).
// Devices are modelled as packet queues. A transaction-level reference model
// predicts, cycle by cycle, which device is granted and where its packet goes.
module tb_bs_gnrtr_n_rbtr;

  localparam int NB = 1;
  localparam int ND = 8;
  localparam int PS = 30;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NB-1:0][ND-1:0]         pndng;
  logic [NB-1:0][ND-1:0][PS-1:0] D_pop;
  logic [NB-1:0][ND-1:0]         pop;
  logic [NB-1:0][ND-1:0]         push;
  logic [NB-1:0][ND-1:0][PS-1:0] D_push;

  bs_gnrtr_n_rbtr #(
    .bits     (NB),
    .drvrs    (ND),
    .pckg_sz  (PS),
    .broadcast(8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pndng (pndng),
    .D_pop (D_pop),
    .pop   (pop),
    .push  (push),
    .D_push(D_push)
  );

  always #5 clk = ~clk;

  // Device FIFOs and reference-model state.
  logic [PS-1:0] fifo [ND][$];
  bit            rst_req;
  bit            m_busy;
  int            m_ptr;
  int            m_src;
  logic [PS-1:0] m_pkt;
  logic [ND-1:0] exp_pop;
  logic [ND-1:0] exp_push;
  logic [PS-1:0] exp_dp;
  int            n_vec;
  int            n_err;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < ND; i++) begin
      pndng[0][i] = (fifo[i].size() > 0);
      D_pop[0][i] = (fifo[i].size() > 0) ? fifo[i][0] : '0;
    end
  endtask

  // One clock cycle: check this cycle's outputs, let devices consume popped
  // heads, apply reset request, drive inputs, then predict the next cycle.
  task automatic cycle();
    logic [7:0] dest;
    bit         found;
    int         i;
    @(negedge clk);
    check_val("pop", pop[0], exp_pop);
    check_val("push", push[0], exp_push);
    for (int j = 0; j < ND; j++) check_val($sformatf("dpush%0d", j), D_push[0][j], exp_dp);
    for (int j = 0; j < ND; j++) begin
      if (exp_pop[j] && fifo[j].size() > 0) void'(fifo[j].pop_front());
    end
    reset = rst_req;
    drive_inputs();
    exp_pop  = '0;
    exp_push = '0;
    if (rst_req) begin
      m_busy = 0;
      m_ptr  = 0;
      exp_dp = '0;
    end else if (!m_busy) begin
      found = 0;
      for (int k = 0; k < ND; k++) begin
        i = (m_ptr + k) % ND;
        if (!found && fifo[i].size() > 0) begin
          found      = 1;
          exp_pop[i] = 1'b1;
          m_pkt      = fifo[i][0];
          m_src      = i;
          m_busy     = 1;
        end
      end
    end else begin
      dest = m_pkt[PS-1 -: 8];
      if (int'(dest) < ND) exp_push[dest[2:0]] = 1'b1;
      else if (dest == 8'hFF) begin
        exp_push        = '1;
        exp_push[m_src] = 1'b0;
      end
      exp_dp = m_pkt;
      m_ptr  = (m_src + 1) % ND;
      m_busy = 0;
    end
  endtask

  function automatic logic [PS-1:0] rand_pkt();
    int unsigned sel;
    logic [7:0]  d;
    sel = $urandom_range(9, 0);
    if (sel < 6)      d = 8'($urandom_range(ND - 1, 0));
    else if (sel < 8) d = 8'hFF;
    else              d = 8'($urandom_range(254, ND));
    return {d, 22'($urandom)};
  endfunction

  initial begin
    bit seen;
    n_vec = 0; n_err = 0;
    m_busy = 0; m_ptr = 0; m_src = 0; m_pkt = '0;
    exp_pop = '0; exp_push = '0; exp_dp = '0;
    pndng = '0; D_pop = '0;
    rst_req = 1;
    #1 reset = 1'b1;

    // Reset then idle.
    repeat (2) cycle();
    rst_req = 0;
    repeat (20) cycle();

    // Unicast 1 -> 2.
    fifo[1].push_back({8'd2, 22'd8});
    repeat (4) cycle();
    check_val("uni_data", D_push[0][2], {8'd2, 22'd8});

    // Broadcast from 3.
    fifo[3].push_back({8'hFF, 22'h15});
    repeat (4) cycle();
    check_val("bcast_data", D_push[0][5], 30'h3FC0_0015);

    // All devices pending straight out of reset.
    rst_req = 1;
    cycle();
    for (int i = 0; i < ND; i++) fifo[i].push_back({8'($urandom_range(ND - 1, 0)), 22'($urandom)});
    rst_req = 0;
    repeat (20) cycle();

    // Invalid destination is dropped; the next pending device is served.
    fifo[0].push_back({8'd20, 22'($urandom)});
    fifo[4].push_back({8'd1, 22'($urandom)});
    repeat (8) cycle();

    // Reset in the cycle after pop[5].
    fifo[5].push_back({8'd6, 22'h1234});
    fifo[2].push_back({8'd0, 22'h55});
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      cycle();
      seen = exp_pop[5];
    end
    check_val("pop5_seen", 64'(seen), 64'd1);
    cycle();
    rst_req = 1;
    cycle();
    rst_req = 0;
    repeat (10) cycle();

    // Random traffic with occasional resets.
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(2, 0) == 0) fifo[$urandom_range(ND - 1, 0)].push_back(rand_pkt());
      if (rst_req) rst_req = 0;
      else if ($urandom_range(199, 0) == 0) rst_req = 1;
      cycle();
    end
    rst_req = 0;
    repeat (60) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
